// File: rtl/laser_pkg.sv
// laser_pkg: shared FSM states, target selects and default geometry
// for the two-circle laser coverage search.
package laser_pkg;

   typedef enum logic [1:0] {
      LOAD,
      SEARCH,
      COMMIT,
      FINISH
   } state_t;

   localparam logic TGT_C1 = 1'b0;
   localparam logic TGT_C2 = 1'b1;

   localparam int COORD_W_DEF    = 4;
   localparam int NUM_OBJ_DEF    = 40;
   localparam int RADIUS_DEF     = 4;
   localparam int MAX_ROUNDS_DEF = 8;

   localparam int          G     = 1 << (2 * COORD_W_DEF);
   localparam int unsigned R2    = RADIUS_DEF * RADIUS_DEF;
   localparam int          CNT_W = $clog2(NUM_OBJ_DEF + 1);

endpackage

// File: rtl/laser_cover_hit.sv
// laser_cover_hit: combinational test whether an object lies inside a circle.
// Ports: cx/cy circle centre, ox/oy object, hit = dx^2+dy^2 <= sq_r.
module laser_cover_hit
   import laser_pkg::*;
#(
   parameter int          COORD_W = COORD_W_DEF,
   parameter int unsigned SQ_R    = R2
) (
   input  logic [COORD_W-1:0] cx,
   input  logic [COORD_W-1:0] cy,
   input  logic [COORD_W-1:0] ox,
   input  logic [COORD_W-1:0] oy,
   output logic               hit
);

   localparam int SW = 2 * COORD_W + 1;

   logic [COORD_W-1:0] dx;
   logic [COORD_W-1:0] dy;
   logic [SW-1:0]      d2;

   always_comb begin
      dx  = (cx > ox) ? (cx - ox) : (ox - cx);
      dy  = (cy > oy) ? (cy - oy) : (oy - cy);
      d2  = SW'(dx) * SW'(dx) + SW'(dy) * SW'(dy);
      hit = (32'(d2) <= SQ_R);
   end

endmodule

// File: rtl/laser_cover_search.sv
// laser_cover_search: buffers a frame of objects, then places two circles by
// alternating raster search. Ports: CLK/RST, IN_VALID/IN_READY/X/Y load,
// C1X/C1Y/C2X/C2Y/COUNT committed result, BUSY while searching, DONE pulse.
module laser_cover_search
   import laser_pkg::*;
#(
   parameter int COORD_W    = COORD_W_DEF,
   parameter int NUM_OBJ    = NUM_OBJ_DEF,
   parameter int RADIUS     = RADIUS_DEF,
   parameter int MAX_ROUNDS = MAX_ROUNDS_DEF
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           IN_VALID,
   output logic                           IN_READY,
   input  logic [COORD_W-1:0]             X,
   input  logic [COORD_W-1:0]             Y,
   output logic [COORD_W-1:0]             C1X,
   output logic [COORD_W-1:0]             C1Y,
   output logic [COORD_W-1:0]             C2X,
   output logic [COORD_W-1:0]             C2Y,
   output logic [$clog2(NUM_OBJ+1)-1:0]   COUNT,
   output logic                           BUSY,
   output logic                           DONE
);

   localparam int          PW       = 2 * COORD_W;
   localparam int          CNT_BITS = $clog2(NUM_OBJ + 1);
   localparam int          IW       = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
   localparam int          RW       = $clog2(MAX_ROUNDS + 1);
   localparam int unsigned SQR      = RADIUS * RADIUS;

   localparam logic [IW-1:0] LAST = IW'(NUM_OBJ - 1);
   localparam logic [RW-1:0] RMAX = RW'(MAX_ROUNDS);

   state_t state;
   state_t state_nx;

   logic [COORD_W-1:0] obj_x [NUM_OBJ];
   logic [COORD_W-1:0] obj_y [NUM_OBJ];

   logic [IW-1:0]       k;
   logic [IW-1:0]       oi;
   logic [PW-1:0]       cand;
   logic [PW-1:0]       best_pos;
   logic [CNT_BITS-1:0] acc;
   logic [CNT_BITS-1:0] total;
   logic [CNT_BITS-1:0] best_cnt;
   logic [CNT_BITS-1:0] rs_cnt;
   logic [RW-1:0]       round;
   logic [RW-1:0]       round_nx;
   logic                tgt;
   logic                accept;
   logic                obj_last;
   logic                pass_end;
   logic                again;
   logic                hit_c;
   logic                hit_o;
   logic [COORD_W-1:0]  ocx;
   logic [COORD_W-1:0]  ocy;

   assign accept   = IN_VALID && IN_READY;
   assign obj_last = (oi == LAST);
   assign pass_end = obj_last && (&cand);
   assign ocx      = (tgt == TGT_C1) ? C2X : C1X;
   assign ocy      = (tgt == TGT_C1) ? C2Y : C1Y;
   assign total    = acc + CNT_BITS'(hit_c || hit_o);
   assign round_nx = round + RW'(1);
   // Another round only pays off if the C2 pass improved on the round start.
   assign again    = (best_cnt > rs_cnt) && (round_nx < RMAX);

   laser_cover_hit #(
      .COORD_W (COORD_W),
      .SQ_R    (SQR)
   ) u_hit_cand (
      .cx  (cand[COORD_W-1:0]),
      .cy  (cand[PW-1:COORD_W]),
      .ox  (obj_x[oi]),
      .oy  (obj_y[oi]),
      .hit (hit_c)
   );

   laser_cover_hit #(
      .COORD_W (COORD_W),
      .SQ_R    (SQR)
   ) u_hit_other (
      .cx  (ocx),
      .cy  (ocy),
      .ox  (obj_x[oi]),
      .oy  (obj_y[oi]),
      .hit (hit_o)
   );

   always_ff @(posedge CLK) begin
      if (accept) begin
         obj_x[k] <= X;
         obj_y[k] <= Y;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= LOAD;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      IN_READY = 1'b0;
      BUSY     = 1'b0;
      DONE     = 1'b0;
      unique case (state)
         LOAD: begin
            IN_READY = 1'b1;
            if (IN_VALID && (k == LAST)) state_nx = SEARCH;
         end
         SEARCH: begin
            BUSY = 1'b1;
            if (pass_end) state_nx = COMMIT;
         end
         COMMIT: begin
            BUSY = 1'b1;
            if ((tgt == TGT_C2) && !again) state_nx = FINISH;
            else                           state_nx = SEARCH;
         end
         FINISH: begin
            DONE     = 1'b1;
            state_nx = LOAD;
         end
         default: state_nx = LOAD;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         k        <= '0;
         oi       <= '0;
         cand     <= '0;
         acc      <= '0;
         best_cnt <= '0;
         best_pos <= '0;
         rs_cnt   <= '0;
         round    <= '0;
         tgt      <= TGT_C1;
         C1X      <= '0;
         C1Y      <= '0;
         C2X      <= '0;
         C2Y      <= '0;
         COUNT    <= '0;
      end else begin
         unique case (state)
            LOAD: begin
               if (accept) begin
                  if (k == '0) begin
                     C1X   <= '0;
                     C1Y   <= '0;
                     C2X   <= '0;
                     C2Y   <= '0;
                     COUNT <= '0;
                  end
                  if (k == LAST) begin
                     k        <= '0;
                     tgt      <= TGT_C1;
                     round    <= '0;
                     rs_cnt   <= '0;
                     cand     <= '0;
                     oi       <= '0;
                     acc      <= '0;
                     best_cnt <= '0;
                     best_pos <= '0;
                  end else begin
                     k <= k + IW'(1);
                  end
               end
            end
            SEARCH: begin
               if (obj_last) begin
                  oi  <= '0;
                  acc <= '0;
                  // Strictly greater keeps the lowest raster index on ties.
                  if (total > best_cnt) begin
                     best_cnt <= total;
                     best_pos <= cand;
                  end
                  cand <= cand + PW'(1);
               end else begin
                  oi  <= oi + IW'(1);
                  acc <= total;
               end
            end
            COMMIT: begin
               COUNT    <= best_cnt;
               cand     <= '0;
               oi       <= '0;
               acc      <= '0;
               best_cnt <= '0;
               best_pos <= '0;
               if (tgt == TGT_C1) begin
                  C1X <= best_pos[COORD_W-1:0];
                  C1Y <= best_pos[PW-1:COORD_W];
                  tgt <= TGT_C2;
               end else begin
                  C2X   <= best_pos[COORD_W-1:0];
                  C2Y   <= best_pos[PW-1:COORD_W];
                  round <= round_nx;
                  if (again) begin
                     tgt    <= TGT_C1;
                     rs_cnt <= best_cnt;
                  end
               end
            end
            FINISH: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule
